// File: rtl/chacha20_block_sequencer_pkg.sv
// Shared types, constants and helpers for the ChaCha20 block sequencer and its quarter-round core.
package chacha20_block_sequencer_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] state_t;

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StOut} fsm_e;

    // Word indices of one quarter-round, a in the top nibble.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
    } qr_sel_t;

    localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    localparam logic [15:0] COL_SEL  [4] = '{16'h048c, 16'h159d, 16'h26ae, 16'h37bf};
    localparam logic [15:0] DIAG_SEL [4] = '{16'h05af, 16'h16bc, 16'h278d, 16'h349e};

    function automatic qr_sel_t qr_sel(input logic [2:0] idx);
        if (idx[2]) begin
            return qr_sel_t'(DIAG_SEL[idx[1:0]]);
        end
        return qr_sel_t'(COL_SEL[idx[1:0]]);
    endfunction

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Feed-forward: per-word add, carries never cross word boundaries.
    function automatic state_t state_add(input state_t x, input state_t y);
        state_t r;
        for (int i = 0; i < 16; i++) begin
            r[i] = x[i] + y[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha20_block_sequencer_if.sv
// Request/keystream bus between the AEAD top level (master) and the block sequencer (slave).
interface chacha20_block_sequencer_if #(
    parameter int unsigned NBLK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [255:0]      req_key;
    logic [95:0]       req_nonce;
    logic [31:0]       req_counter;
    logic [NBLK_W-1:0] req_nblocks;
    logic              out_valid;
    logic              out_ready;
    logic [511:0]      out_block;
    logic [31:0]       out_counter;
    logic              out_last;
    logic              busy;
    logic              ctr_wrap;

    modport master (
        output req_valid, req_key, req_nonce, req_counter, req_nblocks, out_ready,
        input  req_ready, out_valid, out_block, out_counter, out_last, busy, ctr_wrap
    );

    modport slave (
        input  req_valid, req_key, req_nonce, req_counter, req_nblocks, out_ready,
        output req_ready, out_valid, out_block, out_counter, out_last, busy, ctr_wrap
    );
endinterface

// File: rtl/chacha20_block_sequencer_qround.sv
// Combinational ChaCha quarter-round: add/xor/rotate by 16, 12, 8, 7.
module chacha20_block_sequencer_qround
    import chacha20_block_sequencer_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t na,
    output word_t nb,
    output word_t nc,
    output word_t nd
);
    word_t a1, b1, c1, d1;

    always_comb begin
        a1 = a + b;
        d1 = rotl(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotl(b ^ c1, 12);
        na = a1 + b1;
        nd = rotl(d1 ^ na, 8);
        nc = c1 + nd;
        nb = rotl(b1 ^ nc, 7);
    end
endmodule

// File: rtl/chacha20_block_sequencer.sv
// ChaCha20 block sequencer: one quarter-round per cycle, feed-forward, counter auto-increment.
// Optional CHACHA_ZEROIZE_EN clears key/state material and out_block on every return to idle.
module chacha20_block_sequencer
    import chacha20_block_sequencer_pkg::*;
#(
    parameter int unsigned ROUNDS = 20,
    parameter int unsigned NBLK_W = 8
) (
    input logic                      clk,
    input logic                      rst,
    chacha20_block_sequencer_if.slave bus
);
    localparam int unsigned QR_TOTAL = ROUNDS * 4;
    localparam int unsigned QR_W     = $clog2(QR_TOTAL);

    fsm_e              state_q;
    state_t            init_q;
    state_t            work_q;
    logic [QR_W-1:0]   qr_cnt_q;
    logic [NBLK_W-1:0] blocks_left_q;
    logic              req_ready_q;
    logic              busy_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [511:0]      out_block_q;
    word_t             out_counter_q;
    logic              ctr_wrap_q;

    state_t  req_state;
    state_t  next_init;
    qr_sel_t sel;
    word_t   qa, qb, qc, qd;
    word_t   na, nb, nc, nd;

    always_comb begin
        req_state = '0;
        for (int i = 0; i < 4; i++) begin
            req_state[i] = SIGMA[i];
        end
        for (int i = 0; i < 8; i++) begin
            req_state[4+i] = bus.req_key[32*i +: 32];
        end
        req_state[12] = bus.req_counter;
        for (int i = 0; i < 3; i++) begin
            req_state[13+i] = bus.req_nonce[32*i +: 32];
        end
    end

    always_comb begin
        next_init     = init_q;
        next_init[12] = init_q[12] + 32'd1;
    end

    always_comb begin
        sel = qr_sel(qr_cnt_q[2:0]);
        qa  = work_q[sel.a];
        qb  = work_q[sel.b];
        qc  = work_q[sel.c];
        qd  = work_q[sel.d];
    end

    chacha20_block_sequencer_qround u_qround (
        .a  (qa),
        .b  (qb),
        .c  (qc),
        .d  (qd),
        .na (na),
        .nb (nb),
        .nc (nc),
        .nd (nd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            qr_cnt_q      <= '0;
            blocks_left_q <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_block_q   <= '0;
            out_counter_q <= '0;
            ctr_wrap_q    <= 1'b0;
`ifdef CHACHA_ZEROIZE_EN
            init_q        <= '0;
            work_q        <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        init_q        <= req_state;
                        work_q        <= req_state;
                        blocks_left_q <= (bus.req_nblocks == '0) ? NBLK_W'(1) : bus.req_nblocks;
                        qr_cnt_q      <= '0;
                        ctr_wrap_q    <= 1'b0;
                        req_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= StRound;
                    end
                end
                StRound: begin
                    work_q[sel.a] <= na;
                    work_q[sel.b] <= nb;
                    work_q[sel.c] <= nc;
                    work_q[sel.d] <= nd;
                    if (qr_cnt_q == QR_W'(QR_TOTAL - 1)) begin
                        qr_cnt_q <= '0;
                        state_q  <= StFinal;
                    end else begin
                        qr_cnt_q <= qr_cnt_q + 1'b1;
                    end
                end
                StFinal: begin
                    out_block_q   <= state_add(work_q, init_q);
                    out_counter_q <= init_q[12];
                    out_last_q    <= (blocks_left_q == NBLK_W'(1));
                    out_valid_q   <= 1'b1;
                    state_q       <= StOut;
                end
                StOut: begin
                    // Everything holds until the consumer takes the block.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
`ifdef CHACHA_ZEROIZE_EN
                            init_q      <= '0;
                            work_q      <= '0;
                            out_block_q <= '0;
`endif
                        end else begin
                            if (init_q[12] == 32'hffff_ffff) begin
                                ctr_wrap_q <= 1'b1;
                            end
                            init_q        <= next_init;
                            work_q        <= next_init;
                            blocks_left_q <= blocks_left_q - NBLK_W'(1);
                            state_q       <= StRound;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_block   = out_block_q;
    assign bus.out_counter = out_counter_q;
    assign bus.ctr_wrap    = ctr_wrap_q;
endmodule

// File: tb/tb_chacha20_block_sequencer.sv
// Directed bench for chacha20_block_sequencer: RFC 8439 vector, multi-block, wrap, stall, reset, 8-round build.
module tb_chacha20_block_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    logic [255:0] key2;
    logic [95:0]  nonce2;
    logic [511:0] rfc_block;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chacha20_block_sequencer_if #(.NBLK_W(8)) bus ();
    chacha20_block_sequencer_if #(.NBLK_W(8)) bus8 ();

    chacha20_block_sequencer #(.ROUNDS(20), .NBLK_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    chacha20_block_sequencer #(.ROUNDS(8), .NBLK_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] ref_qr(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                               input logic [31:0] ctr, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  w [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
        for (int i = 0; i < 16; i++) w[i] = s[i];
        for (int k = 0; k < rounds / 2; k++) begin
            {w[12], w[8], w[4], w[0]}  = ref_qr(w[0], w[4], w[8], w[12]);
            {w[13], w[9], w[5], w[1]}  = ref_qr(w[1], w[5], w[9], w[13]);
            {w[14], w[10], w[6], w[2]} = ref_qr(w[2], w[6], w[10], w[14]);
            {w[15], w[11], w[7], w[3]} = ref_qr(w[3], w[7], w[11], w[15]);
            {w[15], w[10], w[5], w[0]} = ref_qr(w[0], w[5], w[10], w[15]);
            {w[12], w[11], w[6], w[1]} = ref_qr(w[1], w[6], w[11], w[12]);
            {w[13], w[8], w[7], w[2]}  = ref_qr(w[2], w[7], w[8], w[13]);
            {w[14], w[9], w[4], w[3]}  = ref_qr(w[3], w[4], w[9], w[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [255:0] key, input logic [95:0] nonce,
                            input logic [31:0] ctr, input logic [7:0] nb, output int t0);
        bus.req_key     = key;
        bus.req_nonce   = nonce;
        bus.req_counter = ctr;
        bus.req_nblocks = nb;
        bus.req_valid   = 1'b1;
        t0 = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int t);
        bit seen = 1'b0;
        t = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                t = cyc;
            end else begin
                tick();
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    int t0, t, ths;

    initial begin
        for (int j = 0; j < 32; j++) rfc_key[8*j +: 8] = j[7:0];
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        key2      = ~rfc_key ^ {8{32'h5a17c3e1}};
        nonce2    = {32'hdeadbeef, 32'h01234567, 32'h89abcdef};
        rfc_block = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                     32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                     32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                     32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_key = '0; bus.req_nonce = '0;
        bus.req_counter = '0; bus.req_nblocks = '0; bus.out_ready = 1'b1;
        bus8.req_valid = 1'b0; bus8.req_key = '0; bus8.req_nonce = '0;
        bus8.req_counter = '0; bus8.req_nblocks = '0; bus8.out_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ctr_wrap", bus.ctr_wrap, 0);
        check("rst_out_block", bus.out_block, 0);
        check("rst_out_counter", bus.out_counter, 0);
        rst = 1'b0;
        tick();

        // 1: RFC 8439 block function vector
        send_req(rfc_key, rfc_nonce, 32'd1, 8'd1, t0);
        check("t1_busy", bus.busy, 1);
        check("t1_req_ready", bus.req_ready, 0);
        wait_out("t1", t);
        check("t1_latency", t - t0, 82);
        check("t1_word0", bus.out_block[31:0], 32'he4e7f110);
        check("t1_block", bus.out_block, rfc_block);
        check("t1_last", bus.out_last, 1);
        check("t1_counter", bus.out_counter, 1);
        tick();
        check("t1_valid_drop", bus.out_valid, 0);
        check("t1_ready_back", bus.req_ready, 1);
        check("t1_busy_drop", bus.busy, 0);

        // 2: three back-to-back blocks
        send_req(rfc_key, rfc_nonce, 32'd1, 8'd3, t0);
        ths = t0;
        for (int b = 0; b < 3; b++) begin
            wait_out("t2", t);
            check("t2_latency", t - ths, 82);
            check("t2_counter", bus.out_counter, 1 + b);
            check("t2_last", bus.out_last, (b == 2));
            check("t2_block", bus.out_block, ref_block(rfc_key, rfc_nonce, 32'(1 + b), 20));
            ths = cyc;
            tick();
        end
        check("t2_ready_back", bus.req_ready, 1);

        // 3: counter wrap
        send_req(rfc_key, rfc_nonce, 32'hffffffff, 8'd2, t0);
        wait_out("t3a", t);
        check("t3_counter0", bus.out_counter, 32'hffffffff);
        check("t3_wrap0", bus.ctr_wrap, 0);
        check("t3_last0", bus.out_last, 0);
        check("t3_block0", bus.out_block, ref_block(rfc_key, rfc_nonce, 32'hffffffff, 20));
        tick();
        wait_out("t3b", t);
        check("t3_counter1", bus.out_counter, 0);
        check("t3_wrap1", bus.ctr_wrap, 1);
        check("t3_last1", bus.out_last, 1);
        check("t3_block1", bus.out_block, ref_block(rfc_key, rfc_nonce, 32'h0, 20));
        tick();
        check("t3_wrap_sticky", bus.ctr_wrap, 1);
        check("t3_ready_back", bus.req_ready, 1);

        // 4: back-pressure for 50 cycles
        bus.out_ready = 1'b0;
        send_req(key2, nonce2, 32'd5, 8'd2, t0);
        check("t4_wrap_clear", bus.ctr_wrap, 0);
        wait_out("t4a", t);
        repeat (50) tick();
        check("t4_hold_valid", bus.out_valid, 1);
        check("t4_hold_counter", bus.out_counter, 5);
        check("t4_hold_block", bus.out_block, ref_block(key2, nonce2, 32'd5, 20));
        check("t4_hold_last", bus.out_last, 0);
        check("t4_hold_busy", bus.busy, 1);
        bus.out_ready = 1'b1;
        ths = cyc;
        tick();
        wait_out("t4b", t);
        check("t4_latency", t - ths, 82);
        check("t4_counter1", bus.out_counter, 6);
        check("t4_block1", bus.out_block, ref_block(key2, nonce2, 32'd6, 20));
        check("t4_last1", bus.out_last, 1);
        tick();

        // 5: reset in the middle of ROUND
        send_req(rfc_key, rfc_nonce, 32'd1, 8'd1, t0);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", bus.out_valid, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_req_ready", bus.req_ready, 1);
        check("t5_out_block", bus.out_block, 0);
        check("t5_out_counter", bus.out_counter, 0);
        send_req(rfc_key, rfc_nonce, 32'd1, 8'd1, t0);
        wait_out("t5", t);
        check("t5_latency", t - t0, 82);
        check("t5_block", bus.out_block, rfc_block);
        tick();

        // 6: request while busy is ignored
        send_req(rfc_key, rfc_nonce, 32'd1, 8'd1, t0);
        repeat (10) tick();
        bus.req_key = key2;
        bus.req_counter = 32'd77;
        bus.req_valid = 1'b1;
        check("t6_req_ready_busy", bus.req_ready, 0);
        tick();
        bus.req_valid = 1'b0;
        wait_out("t6", t);
        check("t6_latency", t - t0, 82);
        check("t6_block", bus.out_block, rfc_block);
        check("t6_counter", bus.out_counter, 1);
        tick();
        repeat (100) tick();
        check("t6_no_extra", bus.out_valid, 0);
        check("t6_ready_back", bus.req_ready, 1);

        // 8-round build
        bus8.req_key = rfc_key;
        bus8.req_nonce = rfc_nonce;
        bus8.req_counter = 32'd1;
        bus8.req_nblocks = 8'd0;
        bus8.req_valid = 1'b1;
        t0 = cyc;
        tick();
        bus8.req_valid = 1'b0;
        t = -1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            if (bus8.out_valid) t = cyc;
            else tick();
        end
        check("r8_latency", t - t0, 34);
        check("r8_block", bus8.out_block, ref_block(rfc_key, rfc_nonce, 32'd1, 8));
        check("r8_last", bus8.out_last, 1);
        tick();
        check("r8_ready_back", bus8.req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
